rrf_alloc_ctrl: RTL and testbench

Rename-register (RRF) allocation controller. It sits between decode/dispatch and the Rrf.
- Hands out one RRF tag per cycle in circular order; drives the Rrf allocate port.
- Tracks the commit head, drives Rrf completed_dst_rrftag_i, and returns committed entries to the free pool.
- Restores its allocation pointer and free count on branch misprediction.

---
 rtl/rrf_alloc_ctrl.sv | 88 ++++++++
 tb/tb_rrf_alloc_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rrf_alloc_ctrl.sv
// Rename-register allocation controller: circular tag allocation, commit head tracking,
// free-count bookkeeping and mispredict pointer restore. Optional checker: RRF_ALLOC_ERR_EN.
module rrf_alloc_ctrl #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               alloc_req_i,
  input  logic               stall_dp_i,
  input  logic [1:0]         com_num_i,
  input  logic               prmiss_i,
  input  logic [RRF_SEL-1:0] rrftagfix_i,
`ifdef RRF_ALLOC_ERR_EN
  output logic               err_o,
`endif
  output logic               allocate_rrf_en_o,
  output logic [RRF_SEL-1:0] allocate_rrftag_o,
  output logic [RRF_SEL-1:0] completed_dst_rrftag_o,
  output logic [RRF_SEL:0]   free_num_o,
  output logic               allocate_stall_o
);

  localparam logic [RRF_SEL:0] RRF_NUM_W = (RRF_SEL+1)'(RRF_NUM);

  logic [RRF_SEL-1:0] rrfptr;
  logic [RRF_SEL-1:0] comptr;
  logic [RRF_SEL:0]   freenum;

  logic [1:0]         com_eff;
  logic               grant;
  logic [RRF_SEL-1:0] comptr_n;
  logic [RRF_SEL-1:0] fix_dist;
  logic [RRF_SEL-1:0] rrfptr_n;
  logic [RRF_SEL:0]   freenum_n;

  // An encoding of 3 on the commit count is treated as no commit.
  assign com_eff  = (com_num_i == 2'd3) ? 2'd0 : com_num_i;
  assign grant    = alloc_req_i & ~stall_dp_i & ~prmiss_i & (freenum != '0);
  assign comptr_n = comptr + {{(RRF_SEL-2){1'b0}}, com_eff};
  assign fix_dist = rrftagfix_i - comptr_n;

  always_comb begin
    rrfptr_n  = rrfptr;
    freenum_n = freenum;
    if (prmiss_i) begin
      rrfptr_n  = rrftagfix_i;
      freenum_n = RRF_NUM_W - {1'b0, fix_dist};
    end else begin
      if (grant) rrfptr_n = rrfptr + 1'b1;
      freenum_n = freenum + {{(RRF_SEL-1){1'b0}}, com_eff} - {{RRF_SEL{1'b0}}, grant};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rrfptr  <= '0;
      comptr  <= '0;
      freenum <= RRF_NUM_W;
    end else begin
      rrfptr  <= rrfptr_n;
      comptr  <= comptr_n;
      freenum <= freenum_n;
    end
  end

`ifdef RRF_ALLOC_ERR_EN
  logic [RRF_SEL+1:0] inflight;
  logic               err_set;

  assign inflight = {1'b0, RRF_NUM_W - freenum};
  // Restore distance is compared against in-flight plus this cycle's commit.
  assign err_set  = ({{RRF_SEL{1'b0}}, com_eff} > inflight) |
                    (prmiss_i & ({2'b00, fix_dist} > (inflight + {{RRF_SEL{1'b0}}, com_eff})));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      err_o <= 1'b0;
    else if (err_set) err_o <= 1'b1;
  end
`endif

  assign allocate_rrf_en_o      = grant;
  assign allocate_rrftag_o      = rrfptr;
  assign completed_dst_rrftag_o = comptr;
  assign free_num_o             = freenum;
  assign allocate_stall_o       = (freenum == '0);

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Directed bench for rrf_alloc_ctrl: vector table plus hand-written corner sequences.
module tb_rrf_alloc_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       alloc_req_i;
  logic       stall_dp_i;
  logic [1:0] com_num_i;
  logic       prmiss_i;
  logic [5:0] rrftagfix_i;
  logic       allocate_rrf_en_o;
  logic [5:0] allocate_rrftag_o;
  logic [5:0] completed_dst_rrftag_o;
  logic [6:0] free_num_o;
  logic       allocate_stall_o;
`ifdef RRF_ALLOC_ERR_EN
  logic       err_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  rrf_alloc_ctrl #(.RRF_NUM(64), .RRF_SEL(6)) dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .alloc_req_i            (alloc_req_i),
    .stall_dp_i             (stall_dp_i),
    .com_num_i              (com_num_i),
    .prmiss_i               (prmiss_i),
    .rrftagfix_i            (rrftagfix_i),
`ifdef RRF_ALLOC_ERR_EN
    .err_o                  (err_o),
`endif
    .allocate_rrf_en_o      (allocate_rrf_en_o),
    .allocate_rrftag_o      (allocate_rrftag_o),
    .completed_dst_rrftag_o (completed_dst_rrftag_o),
    .free_num_o             (free_num_o),
    .allocate_stall_o       (allocate_stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       req;
    logic       stall;
    logic [1:0] com;
    logic       pm;
    logic [5:0] fix;
    logic       en;
    logic [5:0] tag;
    logic [5:0] comp;
    logic [6:0] free;
    logic       full;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic req, input logic stall, input logic [1:0] com,
                              input logic pm, input logic [5:0] fix, input logic en,
                              input logic [5:0] tag, input logic [5:0] comp,
                              input logic [6:0] free, input logic full);
    vec_t v;
    v.req = req; v.stall = stall; v.com = com; v.pm = pm; v.fix = fix;
    v.en = en; v.tag = tag; v.comp = comp; v.free = free; v.full = full;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic stall, input logic [1:0] com,
                       input logic pm, input logic [5:0] fix);
    alloc_req_i = req; stall_dp_i = stall; com_num_i = com; prmiss_i = pm; rrftagfix_i = fix;
  endtask

  // Outputs are sampled at the falling edge, inputs change just after the rising edge.
  task automatic check_outs(input string nm, input logic en, input logic [5:0] tag,
                            input logic [5:0] comp, input logic [6:0] free, input logic full);
    @(negedge clk_i);
    chk({nm, ".en"},   32'(allocate_rrf_en_o),      32'(en));
    chk({nm, ".tag"},  32'(allocate_rrftag_o),      32'(tag));
    chk({nm, ".comp"}, 32'(completed_dst_rrftag_o), 32'(comp));
    chk({nm, ".free"}, 32'(free_num_o),             32'(free));
    chk({nm, ".full"}, 32'(allocate_stall_o),       32'(full));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 6'd0);
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b0, 2'd0, 1'b0, 6'd0);
      step();
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 2'd0, 0, 6'd0, 1, 6'd0, 6'd0, 7'd64, 0);
    tbl[1]  = mk(1, 0, 2'd0, 0, 6'd0, 1, 6'd1, 6'd0, 7'd63, 0);
    tbl[2]  = mk(1, 0, 2'd0, 0, 6'd0, 1, 6'd2, 6'd0, 7'd62, 0);
    tbl[3]  = mk(0, 0, 2'd0, 0, 6'd0, 0, 6'd3, 6'd0, 7'd61, 0);
    tbl[4]  = mk(1, 1, 2'd0, 0, 6'd0, 0, 6'd3, 6'd0, 7'd61, 0);
    tbl[5]  = mk(0, 0, 2'd2, 0, 6'd0, 0, 6'd3, 6'd0, 7'd61, 0);
    tbl[6]  = mk(1, 0, 2'd3, 0, 6'd0, 1, 6'd3, 6'd2, 7'd63, 0);
    tbl[7]  = mk(1, 0, 2'd1, 0, 6'd0, 1, 6'd4, 6'd2, 7'd62, 0);
    tbl[8]  = mk(0, 0, 2'd0, 0, 6'd0, 0, 6'd5, 6'd3, 7'd62, 0);
    tbl[9]  = mk(1, 0, 2'd1, 1, 6'd5, 0, 6'd5, 6'd3, 7'd62, 0);
    tbl[10] = mk(0, 0, 2'd0, 0, 6'd0, 0, 6'd5, 6'd4, 7'd63, 0);
    tbl[11] = mk(0, 0, 2'd0, 1, 6'd4, 0, 6'd5, 6'd4, 7'd63, 0);
    tbl[12] = mk(0, 0, 2'd0, 0, 6'd0, 0, 6'd4, 6'd4, 7'd64, 0);

    // Combinational outputs during reset, grant passes through with a full free pool.
    reset_i = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 6'd0);
    check_outs("rst", 1'b1, 6'd0, 6'd0, 7'd64, 1'b0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].req, tbl[i].stall, tbl[i].com, tbl[i].pm, tbl[i].fix);
      check_outs($sformatf("v%0d", i), tbl[i].en, tbl[i].tag, tbl[i].comp, tbl[i].free, tbl[i].full);
      step();
    end
`ifdef RRF_ALLOC_ERR_EN
    chk("tbl.err", 32'(err_o), 32'd0);
`endif

    // Fill all 64 entries, then a request against a full pool.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 2'd0, 1'b0, 6'd0);
      check_outs($sformatf("fill%0d", i), 1'b1, 6'(i), 6'd0, 7'(64 - i), 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 6'd0);
    check_outs("full", 1'b0, 6'd0, 6'd0, 7'd0, 1'b1);
    step();
    // Commit from full does not bypass into the same cycle's grant.
    drive(1'b1, 1'b0, 2'd2, 1'b0, 6'd0);
    check_outs("full_com", 1'b0, 6'd0, 6'd0, 7'd0, 1'b1);
    step();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 6'd0);
    check_outs("full_wrap", 1'b1, 6'd0, 6'd2, 7'd2, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 6'd0);
    check_outs("full_after", 1'b0, 6'd1, 6'd2, 7'd1, 1'b0);

    // Simultaneous commit and allocate.
    do_reset();
    alloc_n(10);
    drive(1'b1, 1'b0, 2'd1, 1'b0, 6'd0);
    check_outs("ca", 1'b1, 6'd10, 6'd0, 7'd54, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 6'd0);
    check_outs("ca_after", 1'b0, 6'd11, 6'd1, 7'd54, 1'b0);

    // Mispredict restore with a same-cycle commit.
    do_reset();
    alloc_n(10);
    drive(1'b1, 1'b0, 2'd2, 1'b1, 6'd4);
    check_outs("pm", 1'b0, 6'd10, 6'd0, 7'd54, 1'b0);
    step();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 6'd0);
    check_outs("pm_after", 1'b1, 6'd4, 6'd2, 7'd62, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'd0, 1'b1, 6'd2);
    check_outs("pm_empty", 1'b0, 6'd5, 6'd2, 7'd61, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 6'd0);
    check_outs("pm_empty_after", 1'b0, 6'd2, 6'd2, 7'd64, 1'b0);
`ifdef RRF_ALLOC_ERR_EN
    chk("legal.err", 32'(err_o), 32'd0);
`endif

    // Asynchronous reset mid-operation.
    alloc_n(3);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 6'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("arst.tag",  32'(allocate_rrftag_o), 32'd0);
    chk("arst.free", 32'(free_num_o),        32'd64);
    @(posedge clk_i);
    #1 reset_i = 1'b0;

`ifdef RRF_ALLOC_ERR_EN
    drive(1'b0, 1'b0, 2'd1, 1'b0, 6'd0);
    step();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 6'd0);
    @(negedge clk_i);
    chk("err.set", 32'(err_o), 32'd1);
    repeat (3) step();
    @(negedge clk_i);
    chk("err.sticky", 32'(err_o), 32'd1);
    do_reset();
    @(negedge clk_i);
    chk("err.clear", 32'(err_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
